// File: rtl/ps2_hex_receiver.sv
// PS/2 keyboard receiver: frames set-2 scan codes and maps the hex-digit keys
// to a 4-bit value, with break-code suppression and an inter-edge timeout.
module ps2_hex_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] a,
  output logic       valid,
  output logic [7:0] code,
  output logic       err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rx_done_q, rx_done_d;
  logic          rx_bad_q, rx_bad_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          brk_q, brk_d;
  logic [3:0]    a_q, a_d;
  logic [7:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic          fall;
  logic          hit;
  logic [3:0]    digit;

  assign fall = clk_prev_q & ~clk_s2_q;

  always_comb begin
    hit   = 1'b1;
    digit = 4'h0;
    case (rx_byte_q)
      8'h45: digit = 4'h0;
      8'h16: digit = 4'h1;
      8'h1E: digit = 4'h2;
      8'h26: digit = 4'h3;
      8'h25: digit = 4'h4;
      8'h2E: digit = 4'h5;
      8'h36: digit = 4'h6;
      8'h3D: digit = 4'h7;
      8'h3E: digit = 4'h8;
      8'h46: digit = 4'h9;
      8'h1C: digit = 4'hA;
      8'h32: digit = 4'hB;
      8'h21: digit = 4'hC;
      8'h23: digit = 4'hD;
      8'h24: digit = 4'hE;
      8'h2B: digit = 4'hF;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    rx_done_d = 1'b0;
    rx_bad_d  = 1'b0;
    rx_byte_d = rx_byte_q;
    brk_d     = brk_q;
    a_d       = a_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (fall || state_q == IDLE) tmo_d = '0;
    else                         tmo_d = tmo_q + TW'(1);

    case (state_q)
      IDLE: if (fall && !dat_s2_q) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (fall) begin
        shift_d   = {dat_s2_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        parity_d = dat_s2_q;
        state_d  = STOP;
      end
      STOP: if (fall) begin
        state_d   = IDLE;
        rx_done_d = 1'b1;
        rx_bad_d  = !(dat_s2_q && (^{shift_q, parity_q}));
        rx_byte_d = shift_q;
      end
      default: state_d = IDLE;
    endcase

    // An edge in the same cycle as the limit keeps the frame alive.
    if (state_q != IDLE && !fall && tmo_q == TMO_LIMIT) begin
      state_d   = IDLE;
      rx_done_d = 1'b1;
      rx_bad_d  = 1'b1;
      tmo_d     = '0;
    end

    // Second stage: a completed frame becomes err, a break-flag update, or a digit.
    if (rx_done_q) begin
      if (rx_bad_q) begin
        err_d = 1'b1;
      end else if (rx_byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (rx_byte_q == 8'hE0) begin
        brk_d = brk_q;
      end else if (brk_q) begin
        brk_d = 1'b0;
      end else if (hit) begin
        a_d     = digit;
        code_d  = rx_byte_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      rx_done_q  <= 1'b0;
      rx_bad_q   <= 1'b0;
      rx_byte_q  <= '0;
      brk_q      <= 1'b0;
      a_q        <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      rx_done_q  <= rx_done_d;
      rx_bad_q   <= rx_bad_d;
      rx_byte_q  <= rx_byte_d;
      brk_q      <= brk_d;
      a_q        <= a_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign a     = a_q;
  assign code  = code_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ps2_hex_receiver.sv
// Scoreboard bench for ps2_hex_receiver: directed PS/2 frames push expected
// responses; a monitor pops and compares on every valid/err pulse.
module tb_ps2_hex_receiver;

  localparam int K_NONE  = 0;
  localparam int K_VALID = 1;
  localparam int K_ERR   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] a;
  logic       valid;
  logic [7:0] code;
  logic       err;

  typedef struct {
    bit         is_err;
    logic [3:0] a;
    logic [7:0] code;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_fall = 0;
  logic [3:0] hold_a = 4'h0;
  logic [7:0] hold_code = 8'h00;

  ps2_hex_receiver #(.TIMEOUT_CYCLES(100)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .a        (a),
    .valid    (valid),
    .code     (code),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (valid || err)) begin
      if (valid && err) begin
        chk("valid_err_overlap", {30'd0, valid, err}, 32'd2);
      end else if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, valid, err}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {31'd0, err}, {31'd0, e.is_err});
        chk("pulse_a", {28'd0, a}, {28'd0, e.a});
        chk("pulse_code", {24'd0, code}, {24'd0, e.code});
        chk("pulse_latency", cyc - last_fall, e.lat);
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (8) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic push(input int kind, input logic [3:0] da, input logic [7:0] dc, input int lat);
    exp_t x;
    if (kind == K_VALID) begin
      hold_a = da;
      hold_code = dc;
    end
    if (kind != K_NONE) begin
      x.is_err = (kind == K_ERR);
      x.a      = hold_a;
      x.code   = hold_code;
      x.lat    = lat;
      sb.push_back(x);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop,
                            input int kind, input logic [3:0] da);
    logic par;
    par = ~(^b) ^ flip_par;
    push(kind, da, b, 4);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stop);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    chk("drained", sb.size(), 0);
  endtask

  task automatic check_hold(input string tag);
    chk({tag, "_a"}, {28'd0, a}, {28'd0, hold_a});
    chk({tag, "_code"}, {24'd0, code}, {24'd0, hold_code});
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pb;
    repeat (3) @(negedge clk);
    chk("rst_a", {28'd0, a}, 32'd0);
    chk("rst_code", {24'd0, code}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b1, K_VALID, 4'hA);

    send_frame(8'hF0, 1'b0, 1'b1, K_NONE, 4'h0);
    send_frame(8'h1C, 1'b0, 1'b1, K_NONE, 4'h0);
    send_frame(8'h16, 1'b0, 1'b1, K_VALID, 4'h1);

    send_frame(8'h45, 1'b1, 1'b1, K_ERR, 4'h0);
    send_frame(8'h45, 1'b0, 1'b0, K_ERR, 4'h0);
    check_hold("after_err");

    // Start plus 5 data bits, then ps2_clk held idle until the timeout fires.
    pb = 8'h2B;
    push(K_ERR, 4'h0, 8'h00, 104);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(pb[i]);
    ps2_data = 1'b1;
    repeat (150) @(negedge clk);
    chk("timeout_drained", sb.size(), 0);
    send_frame(8'h2B, 1'b0, 1'b1, K_VALID, 4'hF);

    send_frame(8'hE0, 1'b0, 1'b1, K_NONE, 4'h0);
    send_frame(8'h45, 1'b0, 1'b1, K_VALID, 4'h0);
    send_frame(8'h1D, 1'b0, 1'b1, K_NONE, 4'h0);
    check_hold("after_unmapped");

    pb = 8'h3D;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(pb[i]);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_a", {28'd0, a}, 32'd0);
    chk("midrst_code", {24'd0, code}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    hold_a = 4'h0;
    hold_code = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_hold("post_rst");
    send_frame(8'h3D, 1'b0, 1'b1, K_VALID, 4'h7);

    repeat (20) @(negedge clk);
    chk("final_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_hex_receiver.md
PS2_HEX_RECEIVER -- requirements
Module: ps2_hex_receiver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000: maximum clk cycles allowed between ps2_clk falling edges inside a frame.
REQ-002 clk  input  1  system clock; all state on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ps2_clk  input  1  PS/2 keyboard clock, asynchronous to clk, idle high.
REQ-005 ps2_data  input  1  PS/2 keyboard data, asynchronous to clk, idle high.
REQ-006 a  output  4  last decoded hex digit (0x0-0xF); drives the 7-segment decoder's a input.
REQ-007 valid  output  1  one-cycle pulse when a and code are updated.
REQ-008 code  output  8  raw set-2 scan code that produced the current a.
REQ-009 err  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-010 The block SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer, with both flops reset to 1.
REQ-011 The block SHALL detect a falling edge when the previous synchronized ps2_clk is 1 and the current one is 0, sampling the synchronized ps2_data in that cycle.
REQ-012 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: edge with data=0 -> DATA with bit count 0; edge with data=1 -> stay in IDLE with no err.
REQ-014 DATA: each edge shifts data in LSB-first; after the 8th bit -> PARITY.
REQ-015 PARITY: the edge stores the parity bit -> STOP.
REQ-016 STOP: the edge completes the frame -> IDLE. The frame is good only if stop=1 and the 8 data bits plus parity have odd parity; otherwise err pulses and the byte is discarded.
REQ-017 Timeout counter:
- clears on every edge and while in IDLE;
- outside IDLE, on reaching TIMEOUT_CYCLES-1 -> IDLE with an err pulse;
- an edge in the same cycle wins, and no timeout occurs.
REQ-018 Good byte 0xF0 SHALL set the break flag and produce no output.
REQ-019 Good byte 0xE0 SHALL be ignored, leaving the break flag unchanged.
REQ-020 Any other good byte with the break flag set SHALL clear the flag and produce no output.
REQ-021 Good byte, break flag clear, byte in the table -> a=digit, code=byte, valid=1 for one cycle. Table: 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7, 3E->8, 46->9, 1C->A, 32->B, 21->C, 23->D, 24->E, 2B->F.
REQ-022 Good byte not in the table (and not F0/E0) SHALL produce no valid and no err, leaving a and code unchanged.
REQ-023 a and code SHALL hold their values between valid pulses.
REQ-024 Latency: the stop-bit edge is processed on the 3rd rising clk edge after the ps2_clk pin falls; valid or err is registered on the 4th.
REQ-025 valid and err SHALL never be high in the same cycle, and each pulse SHALL last exactly one cycle.

Reset
REQ-026 On rst=1, the block SHALL immediately force a=0x0, code=0x00, valid=0, err=0, state=IDLE, break flag=0, bit and timeout counters=0, and synchronizers=1.
REQ-027 Reset mid-frame SHALL abort the frame without an err pulse; the first complete frame after rst falls SHALL decode normally.

Verification
REQ-028 Reset, then frame 0x1C with correct parity -> single valid pulse, a=0xA, code=0x1C, err=0.
REQ-029 Frames F0, 1C, then 16 -> no valid for F0 or 1C; one valid for 16 with a=0x1, code=0x16.
REQ-030 Frame 0x45 with parity bit inverted -> one err pulse, no valid, a/code unchanged. Frame 0x45 with stop=0 -> same response.
REQ-031 With TIMEOUT_CYCLES=100, send start plus 5 data bits, then hold ps2_clk high -> err pulses once 100 cycles after the last edge, state returns to IDLE. A following frame 0x2B -> a=0xF, valid.
REQ-032 Frames E0, 45 -> a=0x0, valid once. Frame 1D (unmapped) -> no valid, no err.
REQ-033 rst pulsed after 4 data bits of a frame -> outputs zero at once, no err. A following frame 0x3D -> a=0x7, code=0x3D, valid.
